// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an SPI controller and the PWM register-bank target.
// All three pins are asynchronous to the target's system clock.
interface spi_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target loading the PWM control register bank.
// Pins are oversampled in the clk domain; nothing here is clocked by sclk.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_peripheral_if.slave  spi,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             wr_strobe
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_hist;
  logic                   ncs_hist;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_rise;
  logic ncs_fall;

  state_t           state;
  frame_t           shift_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             overflow;
  logic             commit_ok;

  // Synchronizer chains plus history flops; reset loads the idle bus levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_hist <= sclk_s;
      ncs_hist  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;

  assign commit_ok = (bit_cnt == CNT_W'(FRAME_BITS)) && !overflow && shift_q.rw &&
                     (shift_q.addr <= ADDR_W'(MAX_ADDR));

  // Frame FSM: shifts on sclk rise while selected, commits on deselect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_q         <= '0;
      bit_cnt         <= '0;
      overflow        <= 1'b0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          // An sclk rise coinciding with the select edge is dropped here.
          if (ncs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            overflow <= 1'b0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= IDLE;
            if (commit_ok) begin
              wr_strobe <= 1'b1;
              case (shift_q.addr)
                ADDR_W'(0): en_reg_out_7_0  <= shift_q.data;
                ADDR_W'(1): en_reg_out_15_8 <= shift_q.data;
                ADDR_W'(2): en_reg_pwm_7_0  <= shift_q.data;
                ADDR_W'(3): en_reg_pwm_15_8 <= shift_q.data;
                ADDR_W'(4): pwm_duty_cycle  <= shift_q.data;
                default: ;
              endcase
            end
          end else if (sclk_rise) begin
            shift_q <= frame_t'({shift_q[FRAME_BITS-2:0], copi_s});
            if (bit_cnt == CNT_W'(FRAME_BITS)) begin
              overflow <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed and randomised bench for spi_peripheral with a reference register model.
// sclk runs at clk/8; all pin changes are made on the falling clk edge.
module tb_spi_peripheral;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  int         checks = 0;
  int         errors = 0;
  int         strobe_cnt = 0;
  logic [7:0] model [5];

  spi_peripheral_if spi ();

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  // wr_strobe is high for a whole clk period, so one negedge sample per pulse.
  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  function automatic logic [7:0] get_reg(input int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [16:0] v, input int n, input int gap);
    spi.ncs = 1'b0;
    cyc(H);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = v[i];
      cyc(H);
      spi.sclk = 1'b1;
      cyc(H);
      spi.sclk = 1'b0;
    end
    cyc(H);
    spi.ncs = 1'b1;
    cyc(gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (get_reg(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 00", i, get_reg(i));
      end
      model[i] = 8'h00;
    end
    checks++;
    if (wr_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: got %b expected 0", wr_strobe);
    end
  endtask

  task automatic test_single_write();
    int s0;
    s0 = strobe_cnt;
    send_bits(17'h08455, 16, 0);
    // ncs driven high at this negedge; next posedge is E0, commit lands on E2.
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (wr_strobe !== (e == 2)) begin
        errors++;
        $display("FAIL t1_strobe_E%0d: got %b expected %b", e, wr_strobe, (e == 2));
      end
      checks++;
      if (pwm_duty_cycle !== ((e >= 2) ? 8'h55 : 8'h00)) begin
        errors++;
        $display("FAIL t1_duty_E%0d: got %h expected %h", e, pwm_duty_cycle,
                 (e >= 2) ? 8'h55 : 8'h00);
      end
    end
    model[4] = 8'h55;
    cyc(4);
    checks++;
    if (strobe_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL t1_strobe_count: got %0d expected 1", strobe_cnt - s0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_reg(i) !== 8'h00) begin
        errors++;
        $display("FAIL t1_other_reg%0d: got %h expected 00", i, get_reg(i));
      end
    end
  endtask

  task automatic test_all_regs();
    logic [15:0] frames [5];
    int s0;
    frames = '{16'h80F0, 16'h810F, 16'h82AA, 16'h8355, 16'h84FF};
    s0 = strobe_cnt;
    for (int k = 0; k < 5; k++) begin
      send_bits({1'b0, frames[k]}, 16, 8);
      model[k] = frames[k][7:0];
    end
    checks++;
    if (strobe_cnt - s0 !== 5) begin
      errors++;
      $display("FAIL t2_strobe_count: got %0d expected 5", strobe_cnt - s0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (get_reg(i) !== model[i]) begin
        errors++;
        $display("FAIL t2_reg%0d: got %h expected %h", i, get_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_rejected_frames();
    logic [16:0] vals [4];
    int          lens [4];
    int          s0;
    vals = '{17'h00012, 17'h08512, 17'h04412, 17'h18411};
    lens = '{16, 16, 15, 17};
    for (int k = 0; k < 4; k++) begin
      s0 = strobe_cnt;
      send_bits(vals[k], lens[k], 8);
      checks++;
      if (strobe_cnt - s0 !== 0) begin
        errors++;
        $display("FAIL t3_case%0d_strobe: got %0d expected 0", k, strobe_cnt - s0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (get_reg(i) !== model[i]) begin
        errors++;
        $display("FAIL t3_reg%0d: got %h expected %h", i, get_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] hi;
    int s0;
    hi = 8'h80;
    spi.ncs = 1'b0;
    cyc(H);
    for (int i = 7; i >= 0; i--) begin
      spi.copi = hi[i];
      cyc(H);
      spi.sclk = 1'b1;
      cyc(H);
      spi.sclk = 1'b0;
    end
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (get_reg(i) !== 8'h00) begin
        errors++;
        $display("FAIL t4_after_reset_reg%0d: got %h expected 00", i, get_reg(i));
      end
    end
    spi.ncs = 1'b1;
    cyc(8);
    s0 = strobe_cnt;
    send_bits(17'h08033, 16, 8);
    model[0] = 8'h33;
    checks++;
    if (strobe_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL t4_strobe_count: got %0d expected 1", strobe_cnt - s0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (get_reg(i) !== model[i]) begin
        errors++;
        $display("FAIL t4_reg%0d: got %h expected %h", i, get_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    spi.ncs = 1'b1;
    for (int k = 0; k < 16; k++) begin
      spi.copi = k[0];
      cyc(H);
      spi.sclk = 1'b1;
      cyc(H);
      spi.sclk = 1'b0;
    end
    cyc(H);
    checks++;
    if (strobe_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL t5_deselected_strobe: got %0d expected 0", strobe_cnt - s0);
    end
    send_bits(17'h08177, 16, 3);
    send_bits(17'h080C3, 16, 8);
    model[1] = 8'h77;
    model[0] = 8'hC3;
    checks++;
    if (strobe_cnt - s0 !== 2) begin
      errors++;
      $display("FAIL t5_strobe_count: got %0d expected 2", strobe_cnt - s0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (get_reg(i) !== model[i]) begin
        errors++;
        $display("FAIL t5_reg%0d: got %h expected %h", i, get_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_random();
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    int         s0;
    int         exp_strobes;
    for (int k = 0; k < 20; k++) begin
      rw   = ($urandom_range(0, 3) != 0);
      addr = 7'($urandom_range(0, 7));
      data = 8'($urandom);
      s0   = strobe_cnt;
      send_bits({1'b0, rw, addr, data}, 16, 6);
      exp_strobes = 0;
      if (rw && addr <= 7'd4) begin
        model[int'(addr)] = data;
        exp_strobes = 1;
      end
      checks++;
      if (strobe_cnt - s0 !== exp_strobes) begin
        errors++;
        $display("FAIL t6_frame%0d_strobe: got %0d expected %0d", k, strobe_cnt - s0,
                 exp_strobes);
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (get_reg(i) !== model[i]) begin
          errors++;
          $display("FAIL t6_frame%0d_reg%0d: got %h expected %h", k, i, get_reg(i),
                   model[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    cyc(1);
    test_reset();
    test_single_write();
    test_all_regs();
    test_rejected_frames();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
